// File: rtl/avalon_master_pkg.sv
// Shared types for the Avalon burst writer: controller states and write response codes.
package avalon_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    WRITE,
    RESP,
    DONE,
    ERROR
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/avalon_addr_gen.sv
// Channel/sample counters and the Avalon byte address for the current word.
module avalon_addr_gen #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 64,
  parameter int unsigned       DEPTH     = 512,
  parameter int unsigned       NUM_CH    = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0] CH_STRIDE = ADDR_W'(DEPTH * DATA_W / 8),
  parameter int unsigned       SA_W      = $clog2(NUM_CH) + $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clr,
  input  logic              adv,
  output logic [SA_W-1:0]   sel,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [IDX_W-1:0] idx;
  logic [CH_W-1:0]  ch;
  logic             idx_wrap;
  logic             ch_wrap;

  assign idx_wrap = (idx == IDX_W'(DEPTH - 1));
  assign ch_wrap  = (ch == CH_W'(NUM_CH - 1));
  assign last     = idx_wrap && ch_wrap;

  always_ff @(posedge clk) begin
    if (n_rst || clr) begin
      idx <= '0;
      ch  <= '0;
    end else if (adv) begin
      if (idx_wrap) begin
        idx <= '0;
        ch  <= ch_wrap ? '0 : ch + 1'b1;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // With a single channel the buffer address is just the sample index.
  if (NUM_CH > 1) begin : g_multi_ch
    assign sel = {ch, idx};
  end else begin : g_single_ch
    assign sel = idx;
  end

  assign addr = BASE_ADDR + ADDR_W'(ch) * CH_STRIDE + ADDR_W'(idx) * ADDR_W'(DATA_W / 8);

endmodule

// File: rtl/avalon_burst_writer.sv
// Copies NUM_CH x DEPTH samples from a sample buffer to an Avalon slave, one
// outstanding write at a time, retrying failed responses up to MAX_RETRY times.
module avalon_burst_writer
  import avalon_master_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 64,
  parameter int unsigned       DEPTH     = 512,
  parameter int unsigned       NUM_CH    = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0] CH_STRIDE = ADDR_W'(DEPTH * DATA_W / 8),
  parameter int unsigned       MAX_RETRY = 3
) (
  input  logic                                      clk,
  input  logic                                      n_rst,
  input  logic                                      fft_done,
  output logic                                      sReEn,
  output logic [$clog2(NUM_CH)+$clog2(DEPTH)-1:0]   sampled_address,
  input  logic [DATA_W-1:0]                         sampled_data,
  output logic                                      wEn,
  output logic [ADDR_W-1:0]                         address,
  output logic [DATA_W-1:0]                         wData,
  input  logic                                      waitrequest,
  input  logic                                      resp_valid,
  input  logic [1:0]                                response,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      error,
  input  logic                                      err_clr
);

  localparam int unsigned SA_W    = $clog2(NUM_CH) + $clog2(DEPTH);
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t              state, state_nx;
  logic [RETRY_W-1:0]  retry;
  logic [DATA_W-1:0]   wdata_q;
  logic                error_q;
  logic                clr, adv, last;
  logic                resp_ok, can_retry;
  logic [SA_W-1:0]     sel;
  logic [ADDR_W-1:0]   addr;

  avalon_addr_gen #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NUM_CH   (NUM_CH),
    .BASE_ADDR(BASE_ADDR),
    .CH_STRIDE(CH_STRIDE),
    .SA_W     (SA_W)
  ) u_addr_gen (
    .clk  (clk),
    .n_rst(n_rst),
    .clr  (clr),
    .adv  (adv),
    .sel  (sel),
    .last (last),
    .addr (addr)
  );

  assign resp_ok   = (response == OKAY);
  assign can_retry = (retry < RETRY_W'(MAX_RETRY));

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    adv      = 1'b0;
    case (state)
      IDLE: begin
        if (fft_done && !error_q) begin
          state_nx = FETCH;
          clr      = 1'b1;
        end
      end
      FETCH: state_nx = LOAD;
      LOAD:  state_nx = WRITE;
      WRITE: if (!waitrequest) state_nx = RESP;
      RESP: begin
        if (resp_valid) begin
          if (resp_ok) begin
            adv      = 1'b1;
            state_nx = last ? DONE : FETCH;
          end else if (can_retry) begin
            state_nx = WRITE;
          end else begin
            state_nx = ERROR;
          end
        end
      end
      DONE:    state_nx = IDLE;
      ERROR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state   <= IDLE;
      retry   <= '0;
      wdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (clr) begin
        retry <= '0;
      end else if (state == RESP && resp_valid) begin
        if (resp_ok)        retry <= '0;
        else if (can_retry) retry <= retry + 1'b1;
      end
      if (state == LOAD) wdata_q <= sampled_data;
      // Entering the error state takes priority over a simultaneous clear.
      if (state == ERROR)  error_q <= 1'b1;
      else if (err_clr)    error_q <= 1'b0;
    end
  end

  assign sReEn           = (state == FETCH);
  assign sampled_address = sReEn ? sel : '0;
  assign wEn             = (state == WRITE);
  assign address         = wEn ? addr : '0;
  assign wData           = wdata_q;
  assign busy            = state inside {FETCH, LOAD, WRITE, RESP};
  assign done            = (state == DONE);
  assign error           = error_q;

endmodule

// File: tb/tb_avalon_burst_writer.sv
// Self-checking bench: a word-level model predicts reads, writes, busy/done/error
// each cycle, while a scripted/randomized slave supplies stalls and responses.
module tb_avalon_burst_writer;
  import avalon_master_pkg::*;

  localparam int DW = 16, AW = 64, SAW = 3, NWORDS = 8, MR = 2;

  logic           clk = 1'b0;
  logic           n_rst = 1'b1, fft_done = 1'b0, err_clr = 1'b0;
  logic           sReEn, wEn, busy, done, error;
  logic [SAW-1:0] sampled_address;
  logic [DW-1:0]  sampled_data = '0;
  logic [AW-1:0]  address;
  logic [DW-1:0]  wData;
  logic           waitrequest = 1'b0, resp_valid = 1'b0;
  logic [1:0]     response = 2'b00;

  always #5 clk = ~clk;

  avalon_burst_writer #(
    .DATA_W   (16),
    .DEPTH    (4),
    .NUM_CH   (2),
    .BASE_ADDR(64'h1000),
    .CH_STRIDE(64'h100),
    .MAX_RETRY(2)
  ) dut (
    .clk(clk), .n_rst(n_rst), .fft_done(fft_done),
    .sReEn(sReEn), .sampled_address(sampled_address), .sampled_data(sampled_data),
    .wEn(wEn), .address(address), .wData(wData), .waitrequest(waitrequest),
    .resp_valid(resp_valid), .response(response),
    .busy(busy), .done(done), .error(error), .err_clr(err_clr)
  );

  int total = 0, bad = 0;
  int t = 0;

  // Word-level model of the transfer
  bit xfer = 0, resp_pending = 0, err_m = 0;
  int word = 0, fails = 0, rdelay = 0;
  int rd_at = -1, wr_from = -1, done_at = -1, err_at = -1, err_set_at = -1;

  // Scenario knobs
  bit req_start = 0, req_clr = 0, rand_mode = 0;
  int rst_cycles = 2;
  int stall_word = -1, stall_left = 0, fail_word = -1, fail_left = 0;
  logic [1:0] fail_code = SLVERR;

  // Observations used for the hand-computed pins
  int wr_cnt, done_cnt, busy_cnt, wen_1004_cnt, done_seen, t0;
  logic [AW-1:0] wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];
  bit prev_sren = 0;
  logic [SAW-1:0] prev_sa = '0;
  logic [15:0] salt;

  function automatic logic [15:0] mem(input int sa);
    return salt ^ 16'(sa * 32'h1357 + 32'h0101);
  endfunction

  function automatic logic [63:0] exp_addr(input int w);
    return 64'h1000 + 64'(w / 4) * 64'h100 + 64'(w % 4) * 64'd2;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, t);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at cycle %0d", name, t);
  endtask

  task automatic clear_obs();
    wr_cnt = 0; done_cnt = 0; busy_cnt = 0; wen_1004_cnt = 0; done_seen = -1;
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  // One clock cycle: compare, drive the slave for the coming edge, advance the model.
  task automatic step();
    bit e_sren, e_wen, acc, rsp, idle_now;
    @(negedge clk);
    t++;
    if (t == err_set_at) err_m = 1;
    e_sren   = (t == rd_at);
    e_wen    = (wr_from >= 0) && (t >= wr_from);
    idle_now = !xfer && (t != done_at) && (t != err_at);

    check("busy", busy, xfer);
    check("done", done, t == done_at);
    check("error", error, err_m);
    check("sReEn", sReEn, e_sren);
    if (e_sren && sReEn) check("sampled_address", sampled_address, word);
    check("wEn", wEn, e_wen);
    if (e_wen && wEn) begin
      check("address", address, exp_addr(word));
      check("wData", wData, mem(word));
    end

    if (busy) busy_cnt++;
    if (done) begin done_cnt++; done_seen = t; end
    if (wEn && address == 64'h1004) wen_1004_cnt++;

    n_rst = (rst_cycles > 0);
    if (rst_cycles > 0) rst_cycles--;
    fft_done  = req_start || (rand_mode && $urandom_range(0, 40) == 0);
    req_start = 0;
    err_clr   = req_clr || (rand_mode && $urandom_range(0, 60) == 0);
    req_clr   = 0;
    sampled_data = prev_sren ? mem(int'(prev_sa)) : 16'($urandom);
    prev_sren = sReEn;
    prev_sa   = sampled_address;

    waitrequest = 1'b0;
    if (e_wen && word == stall_word && stall_left > 0) begin
      waitrequest = 1'b1;
      stall_left--;
    end else if (rand_mode) begin
      waitrequest = ($urandom_range(0, 2) == 0);
    end

    resp_valid = 1'b0;
    response   = OKAY;
    if (resp_pending) begin
      if (rdelay > 0) rdelay--;
      else begin
        resp_valid = 1'b1;
        if (word == fail_word && fail_left > 0) begin
          response = fail_code;
          fail_left--;
        end else if (rand_mode && $urandom_range(0, 4) == 0) begin
          response = 2'($urandom_range(1, 3));
        end
      end
    end else if (rand_mode) begin
      resp_valid = ($urandom_range(0, 5) == 0);
      response   = 2'($urandom_range(0, 3));
    end

    acc = e_wen && !waitrequest;
    rsp = resp_pending && resp_valid;
    if (acc) begin
      wr_cnt++;
      wr_addr_log.push_back(address);
      wr_data_log.push_back(wData);
      wr_from      = -1;
      resp_pending = 1;
      rdelay       = rand_mode ? int'($urandom_range(0, 2)) : 0;
    end
    if (rsp) begin
      resp_pending = 0;
      if (response == OKAY) begin
        fails = 0;
        word++;
        if (word == NWORDS) begin
          xfer = 0; done_at = t + 1;
        end else begin
          rd_at = t + 1; wr_from = t + 3;
        end
      end else if (fails < MR) begin
        fails++;
        wr_from = t + 1;
      end else begin
        xfer = 0; err_at = t + 1; err_set_at = t + 2;
      end
    end
    if (fft_done && idle_now && !err_m) begin
      xfer = 1; word = 0; fails = 0; rd_at = t + 1; wr_from = t + 3;
    end
    if (err_clr && t != err_at) err_m = 0;
    if (n_rst) begin
      xfer = 0; word = 0; fails = 0; resp_pending = 0; err_m = 0;
      rd_at = -1; wr_from = -1; done_at = -1; err_at = -1; err_set_at = -1;
    end
  endtask

  task automatic run_to_idle(input int budget);
    int n = 0;
    while ((xfer || t < done_at || t < err_set_at) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) timeout("run_to_idle");
  endtask

  task automatic wait_word(input int w, input bit in_resp, input int budget);
    int n = 0;
    while (!(word == w && (!in_resp || resp_pending)) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) timeout("wait_word");
  endtask

  task automatic start_xfer();
    req_start = 1;
    step();
    t0 = t;
  endtask

  initial begin
    salt = 16'($urandom);
    repeat (3) step();
    check("rst_sReEn", sReEn, 0);
    check("rst_wEn", wEn, 0);
    check("rst_address", address, 0);
    check("rst_wData", wData, 0);
    check("rst_sampled_address", sampled_address, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);

    // Nominal transfer
    clear_obs();
    start_xfer();
    run_to_idle(200);
    check("nom_writes", wr_cnt, 8);
    check("nom_latency", done_seen - t0, 33);
    check("nom_busy_cycles", busy_cnt, 32);
    check("nom_done_pulses", done_cnt, 1);
    if (wr_addr_log.size() == 8) begin
      check("nom_addr0", wr_addr_log[0], 64'h1000);
      check("nom_addr3", wr_addr_log[3], 64'h1006);
      check("nom_addr4", wr_addr_log[4], 64'h1100);
      check("nom_addr7", wr_addr_log[7], 64'h1106);
    end
    check("nom_busy_after", busy, 0);

    // Stall on word 2
    clear_obs();
    stall_word = 2; stall_left = 3;
    start_xfer();
    run_to_idle(200);
    check("stall_writes", wr_cnt, 8);
    check("stall_hold_cycles", wen_1004_cnt, 4);
    check("stall_latency", done_seen - t0, 36);
    stall_word = -1;

    // One SLVERR on 0x1002
    clear_obs();
    fail_word = 1; fail_left = 1; fail_code = SLVERR;
    start_xfer();
    run_to_idle(200);
    check("retry_writes", wr_cnt, 9);
    if (wr_addr_log.size() == 9) begin
      check("retry_addr_a", wr_addr_log[1], 64'h1002);
      check("retry_addr_b", wr_addr_log[2], 64'h1002);
      check("retry_data_b", wr_data_log[2], mem(1));
    end
    check("retry_latency", done_seen - t0, 35);
    check("retry_error", error, 0);

    // Three DECERR on 0x1100
    clear_obs();
    fail_word = 4; fail_left = 3; fail_code = DECERR;
    start_xfer();
    run_to_idle(200);
    check("fail_writes", wr_cnt, 7);
    check("fail_done_pulses", done_cnt, 0);
    check("fail_error", error, 1);
    fail_word = -1;
    clear_obs();
    req_start = 1;
    repeat (10) step();
    check("fail_ignored_busy", busy_cnt, 0);
    check("fail_ignored_writes", wr_cnt, 0);
    req_clr = 1;
    step();
    step();
    check("fail_cleared", error, 0);

    // Reset during the response of 0x1100
    clear_obs();
    start_xfer();
    wait_word(4, 1, 200);
    rst_cycles = 1;
    step();
    step();
    check("midrst_sReEn", sReEn, 0);
    check("midrst_wEn", wEn, 0);
    check("midrst_address", address, 0);
    check("midrst_wData", wData, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    clear_obs();
    start_xfer();
    run_to_idle(200);
    check("midrst_writes", wr_cnt, 8);
    if (wr_addr_log.size() > 0) check("midrst_first_addr", wr_addr_log[0], 64'h1000);

    // Start pulse while busy
    clear_obs();
    start_xfer();
    wait_word(2, 0, 200);
    req_start = 1;
    run_to_idle(200);
    check("busy_start_writes", wr_cnt, 8);
    check("busy_start_done", done_cnt, 1);
    check("busy_start_latency", done_seen - t0, 33);

    // Randomized traffic
    rand_mode = 1;
    for (int i = 0; i < 12; i++) begin
      req_start = 1;
      step();
      run_to_idle(800);
      if (err_m) begin
        req_clr = 1;
        step();
        step();
      end
    end
    rand_mode = 0;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
